// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile
//   Write-back stage and 32-entry integer register file for the 5-stage
//   pipelined CPU. Selects the write-back data from the MEM/WB outputs,
//   commits it into the register file, serves two combinational read
//   ports for the ID stage and counts retired register writes.
//
// Ports
//   clock   : system clock, rising edge
//   resetn  : asynchronous active-low reset (clears registers and wb_cnt)
//   wwreg   : write-back enable
//   wm2reg  : 1 selects wmo, 0 selects walu
//   wrn     : destination register number
//   wmo     : memory load data
//   walu    : ALU result
//   rna/rnb : read port register numbers
//   qa/qb   : read port data (r0 always reads 0)
//   wdi     : selected write-back data (also feeds forwarding muxes)
//   wb_cnt  : wrapping count of committed register writes (r0 not counted)
//
// Build option
//   RF_BYPASS_EN : when defined, a read of the register being written in
//                  the same cycle returns wdi instead of the stored value.

module pipe_wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            wwreg,
  input  logic            wm2reg,
  input  logic [4:0]      wrn,
  input  logic [DW-1:0]   wmo,
  input  logic [DW-1:0]   walu,
  input  logic [4:0]      rna,
  input  logic [4:0]      rnb,
  output logic [DW-1:0]   qa,
  output logic [DW-1:0]   qb,
  output logic [DW-1:0]   wdi,
  output logic [CNTW-1:0] wb_cnt
);

  logic [DW-1:0]   regs [NREG];
  logic [CNTW-1:0] cnt;
  logic            commit;

  assign wdi    = wm2reg ? wmo : walu;
  assign commit = wwreg && (wrn != 5'd0) && (int'(wrn) < NREG);
  assign wb_cnt = cnt;

  // Entry 0 is reset and never written, so it stays 0; reads also force 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (commit) begin
      regs[wrn] <= wdi;
      cnt       <= cnt + CNTW'(1);
    end
  end

  always_comb begin
    qa = '0;
    if (rna != 5'd0 && int'(rna) < NREG) qa = regs[rna];
`ifdef RF_BYPASS_EN
    // commit already excludes r0; resetn gating keeps reads at 0 in reset.
    if (resetn && commit && rna == wrn) qa = wdi;
`endif
  end

  always_comb begin
    qb = '0;
    if (rnb != 5'd0 && int'(rnb) < NREG) qb = regs[rnb];
`ifdef RF_BYPASS_EN
    if (resetn && commit && rnb == wrn) qb = wdi;
`endif
  end

endmodule

// File: tb/tb_pipe_wb_regfile.sv
module tb_pipe_wb_regfile;

  localparam int CW = 8; // narrow counter so the wrap boundary is reachable

  logic          clock;
  logic          resetn;
  logic          wwreg, wm2reg;
  logic [4:0]    wrn, rna, rnb;
  logic [31:0]   wmo, walu;
  logic [31:0]   qa, qb, wdi;
  logic [CW-1:0] wb_cnt;

  pipe_wb_regfile #(.NREG(32), .DW(32), .CNTW(CW)) dut (
    .clock(clock), .resetn(resetn), .wwreg(wwreg), .wm2reg(wm2reg),
    .wrn(wrn), .wmo(wmo), .walu(walu), .rna(rna), .rnb(rnb),
    .qa(qa), .qb(qb), .wdi(wdi), .wb_cnt(wb_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         tag;
    logic [31:0]   qa, qb, wdi;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: architectural register array and commit count.
  logic [31:0]   mrf [32];
  logic [CW-1:0] mcnt;

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic cm,
                                             input logic [4:0] wn, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (cm && ra == wn) return wd;
`endif
    return mrf[ra];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  // One cycle of stimulus: drive at negedge, push expectation for this cycle,
  // then advance the model past the coming rising edge.
  task automatic cyc(input logic rst, input logic ww, input logic m2, input logic [4:0] wn,
                     input logic [31:0] mo, input logic [31:0] alu,
                     input logic [4:0] ra, input logic [4:0] rb, input string tag);
    exp_t e;
    logic cm;
    @(negedge clock);
    resetn = rst; wwreg = ww; wm2reg = m2; wrn = wn; wmo = mo; walu = alu;
    rna = ra; rnb = rb;
    #1;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      mcnt = '0;
    end
    e.tag = tag;
    e.wdi = m2 ? mo : alu;
    cm    = rst && ww && (wn != 5'd0);
    e.qa  = model_read(ra, cm, wn, e.wdi);
    e.qb  = model_read(rb, cm, wn, e.wdi);
    e.cnt = mcnt;
    sbq.push_back(e);
    if (cm) begin
      mrf[wn] = e.wdi;
      mcnt    = mcnt + CW'(1);
    end
  endtask

  // Monitor: samples mid-cycle, after the driver has pushed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".wdi"}, wdi, e.wdi);
        chk({e.tag, ".qa"}, qa, e.qa);
        chk({e.tag, ".qb"}, qb, e.qb);
        chk({e.tag, ".wb_cnt"}, 32'(wb_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] wn, ra;
    resetn = 1'b0; wwreg = 1'b0; wm2reg = 1'b0; wrn = '0;
    wmo = '0; walu = '0; rna = '0; rnb = '0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    mcnt = '0;

    // Reset, then idle with reset released
    cyc(0, 0, 0, 0, 0, 0, 5, 31, "rst");
    cyc(0, 0, 0, 0, 0, 0, 5, 31, "rst");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 5, 31, "idle");

    // ALU and memory select
    cyc(1, 1, 0, 3, 32'hDEAD_BEEF, 32'h0000_1234, 3, 4, "alu_wr");
    cyc(1, 1, 1, 4, 32'hDEAD_BEEF, 32'h0000_1234, 3, 4, "mem_wr");
    cyc(1, 0, 0, 0, 0, 0, 3, 4, "sel_rd");

    // r0 protection
    cyc(1, 1, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, "r0_wr");
    cyc(1, 0, 0, 0, 0, 0, 0, 3, "r0_rd");
    cyc(1, 0, 0, 0, 0, 0, 4, 0, "r0_rd2");

    // Same-cycle read of the register being written
    cyc(1, 1, 0, 7, 0, 32'h11, 0, 0, "pre7");
    cyc(1, 1, 0, 7, 0, 32'h22, 7, 7, "same7");
    cyc(1, 0, 0, 0, 0, 0, 7, 7, "post7");

    // Counter wrap
    while (mcnt != '1)
      cyc(1, 1, $urandom_range(0, 1), 5'($urandom_range(1, 31)), $urandom, $urandom,
          5'($urandom), 5'($urandom), "fill");
    cyc(1, 1, 0, 12, 0, 32'h0000_ABCD, 12, 0, "wrap_wr");
    cyc(1, 0, 0, 0, 0, 0, 12, 12, "wrap_rd");

    // Reset during a write, then a normal write
    cyc(0, 1, 0, 9, 0, 32'h55, 9, 9, "rst_wr");
    cyc(1, 0, 0, 0, 0, 0, 9, 9, "rst_rd");
    cyc(1, 1, 0, 9, 0, 32'h55, 9, 0, "rel_wr");
    cyc(1, 0, 0, 0, 0, 0, 9, 9, "rel_rd");

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      wn = 5'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
      cyc($urandom_range(0, 59) != 0, $urandom_range(0, 1), $urandom_range(0, 1), wn,
          $urandom, $urandom, ra, ($urandom_range(0, 3) == 0) ? wn : 5'($urandom), "rand");
    end

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clock);
    @(negedge clock);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
